// File: rtl/eep_pio_pkg.sv
// Shared definitions for the bit-banged serial-bus PIO: register offsets and
// edge-type encodings.
package eep_pio_pkg;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_DIR     = 3'd1;
  localparam logic [2:0] REG_IRQMASK = 3'd2;
  localparam logic [2:0] REG_EDGECAP = 3'd3;
  localparam logic [2:0] REG_OUTSET  = 3'd4;
  localparam logic [2:0] REG_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/eep_i2c_pio_sync_edge.sv
// Per-pin input path: synchroniser chain, previous-sample flop and a
// combinational edge pulse qualified by the warm-up enable.
module eep_sync_edge
  import eep_pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_ANY
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic pin,
  output logic sync,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   det;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  always_comb begin
    det = 1'b0;
    case (EDGE_TYPE)
      EDGE_RISE: det = sync & ~prev;
      EDGE_FALL: det = ~sync & prev;
      default:   det = sync ^ prev;
    endcase
  end

  assign pulse = en & det;

endmodule

// File: rtl/eep_i2c_pio.sv
// Avalon-MM PIO for bit-banged buses: register file, read mux, pad drive,
// warm-up counter and edge-capture interrupt.
module eep_i2c_pio
  import eep_pio_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1,
  parameter int               OPEN_DRAIN  = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  localparam int WCNT = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] data_out, dir, mask, edgecap;
  logic [WIDTH-1:0] sync_in, pulse, w1c, wd, rd;
  logic [WCNT-1:0]  warm;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign w1c       = (wr && address == REG_EDGECAP) ? wd : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    eep_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (warm == '0),
      .pin    (pin_in[i]),
      .sync   (sync_in[i]),
      .pulse  (pulse[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      dir      <= '0;
      mask     <= '0;
      edgecap  <= '0;
      warm     <= WCNT'(SYNC_STAGES + 1);
    end else begin
      if (warm != '0) warm <= warm - 1'b1;
      // a detected edge outranks a same-cycle clear of that bit
      edgecap <= (edgecap & ~w1c) | pulse;
      if (wr) begin
        case (address)
          REG_DATA:    data_out <= wd;
          REG_DIR:     dir      <= wd;
          REG_IRQMASK: mask     <= wd;
          REG_OUTSET:  data_out <= data_out | wd;
          REG_OUTCLR:  data_out <= data_out & ~wd;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      REG_DATA:    rd = sync_in;
      REG_DIR:     rd = dir;
      REG_IRQMASK: rd = mask;
      REG_EDGECAP: rd = edgecap;
      REG_OUTSET,
      REG_OUTCLR:  rd = data_out;
      default:     rd = '0;
    endcase
    readdata             = '0;
    readdata[WIDTH-1:0]  = rd;
  end

  if (OPEN_DRAIN != 0) begin : g_od
    assign pin_oe  = dir & ~data_out;
    assign pin_out = '0;
  end else begin : g_pp
    assign pin_oe  = dir;
    assign pin_out = data_out;
  end

  assign irq = |(edgecap & mask);

endmodule

// File: tb/tb_eep_i2c_pio.sv
// Bench for eep_i2c_pio: an open-drain falling-edge instance and a push-pull
// any-edge instance share one bus, checked against a sample-history model.
module tb_eep_i2c_pio;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic [2:0]  address = '0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [1:0]  pin_in = 2'b11;
  logic [31:0] rd_od, rd_pp;
  logic [1:0]  out_od, oe_od, out_pp, oe_pp;
  logic        irq_od, irq_pp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  eep_i2c_pio #(.WIDTH(2), .OPEN_DRAIN(1), .SYNC_STAGES(S), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(rd_od),
    .pin_in(pin_in), .pin_out(out_od), .pin_oe(oe_od), .irq(irq_od));

  eep_i2c_pio #(.WIDTH(2), .OPEN_DRAIN(0), .SYNC_STAGES(S), .EDGE_TYPE(2)) dut_pp (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(rd_pp),
    .pin_in(pin_in), .pin_out(out_pp), .pin_oe(oe_pp), .irq(irq_pp));

  // Model: hist[0] is the newest pin sample; the readable pin value lags
  // S-1 samples behind, and its predecessor is one further back.
  logic [1:0] hist [0:S];
  int         edges;
  logic [1:0] m_dout, m_dir, m_mask, m_ec_f, m_ec_a;

  always @(posedge clk) begin
    logic [1:0] fin, prv, wd, clr;
    logic       w;
    if (!reset_n) begin
      for (int i = 0; i <= S; i++) hist[i] = 2'b00;
      edges  = 0;
      m_dout = 2'b11;
      m_dir  = 2'b00;
      m_mask = 2'b00;
      m_ec_f = 2'b00;
      m_ec_a = 2'b00;
    end else begin
      edges++;
      fin = hist[S-1];
      prv = hist[S];
      w   = chipselect && !write_n;
      wd  = writedata[1:0];
      clr = (w && address == 3) ? wd : 2'b00;
      m_ec_f = m_ec_f & ~clr;
      m_ec_a = m_ec_a & ~clr;
      if (edges >= S + 2) begin
        m_ec_f = m_ec_f | (prv & ~fin);
        m_ec_a = m_ec_a | (prv ^ fin);
      end
      if (w) begin
        case (address)
          0: m_dout = wd;
          1: m_dir  = wd;
          2: m_mask = wd;
          4: m_dout = m_dout | wd;
          5: m_dout = m_dout & ~wd;
          default: ;
        endcase
      end
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pin_in;
    end
  end

  function automatic logic [31:0] exp_rd(input int a, input bit pp);
    case (a)
      0: return {30'd0, hist[S-1]};
      1: return {30'd0, m_dir};
      2: return {30'd0, m_mask};
      3: return {30'd0, pp ? m_ec_a : m_ec_f};
      4, 5: return {30'd0, m_dout};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic rd_chk(input int a, input string tag, input logic [31:0] exp_od);
    address = 3'(a);
    #1;
    chk(tag, rd_od, exp_od);
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("%s od rd%0d", tag, a), rd_od, exp_rd(a, 1'b0));
      chk($sformatf("%s pp rd%0d", tag, a), rd_pp, exp_rd(a, 1'b1));
    end
    chk({tag, " od oe"},  {30'd0, oe_od},  {30'd0, m_dir & ~m_dout});
    chk({tag, " od out"}, {30'd0, out_od}, 32'd0);
    chk({tag, " pp oe"},  {30'd0, oe_pp},  {30'd0, m_dir});
    chk({tag, " pp out"}, {30'd0, out_pp}, {30'd0, m_dout});
    chk({tag, " od irq"}, {31'd0, irq_od}, {31'd0, |(m_ec_f & m_mask)});
    chk({tag, " pp irq"}, {31'd0, irq_pp}, {31'd0, |(m_ec_a & m_mask)});
  endtask

  // called at a negedge; returns at the next negedge with the bus idle
  task automatic wr(input int a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = 3'(a); writedata = d;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // reset with idle-high pins
    @(negedge clk);
    tick(2);
    chk("rst od oe", {30'd0, oe_od}, 32'd0);
    chk("rst od irq", {31'd0, irq_od}, 32'd0);
    reset_n = 1'b1;
    tick(2);
    rd_chk(0, "data after 2 clks", 32'h3);
    tick(4);
    rd_chk(3, "edgecap after warmup", 32'h0);
    check_all("warm");

    // direction and atomic set/clear
    wr(1, 32'h3);
    wr(5, 32'h1);
    chk("outclr od oe", {30'd0, oe_od}, 32'h1);
    chk("outclr pp oe", {30'd0, oe_pp}, 32'h3);
    chk("outclr pp out", {30'd0, out_pp}, 32'h2);
    check_all("outclr");
    wr(4, 32'h1);
    chk("outset od oe", {30'd0, oe_od}, 32'h0);
    check_all("outset");

    // falling edge on pin 0 lands exactly three clocks later
    wr(2, 32'h1);
    pin_in[0] = 1'b0;
    tick(2);
    rd_chk(3, "ecap clk2", 32'h0);
    tick(1);
    rd_chk(3, "ecap clk3", 32'h1);
    chk("irq set", {31'd0, irq_od}, 32'h1);
    check_all("fall");
    wr(3, 32'h3);
    chk("irq cleared", {31'd0, irq_od}, 32'h0);
    check_all("w1c");

    // detected edge and W1C on the same clock: the set wins
    pin_in[0] = 1'b1;
    tick(4);
    wr(3, 32'h3);
    pin_in[0] = 1'b0;
    tick(2);
    wr(3, 32'h1);
    rd_chk(3, "set beats clear", 32'h1);
    check_all("race");

    // high bits and unmapped offsets
    wr(1, 32'hFFFF_FFFF);
    wr(6, 32'hFFFF_FFFF);
    rd_chk(1, "dir width", 32'h3);
    rd_chk(6, "addr6", 32'h0);
    check_all("unmapped");

    // reset mid-transfer with outputs driven low
    wr(2, 32'h3);
    wr(0, 32'h0);
    chk("pre-rst od oe", {30'd0, oe_od}, 32'h3);
    chk("pre-rst irq", {31'd0, irq_od}, 32'h1);
    reset_n = 1'b0;
    chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata = 32'h3;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    chk("rst od oe", {30'd0, oe_od}, 32'h0);
    chk("rst pp oe", {30'd0, oe_pp}, 32'h0);
    chk("rst irq", {31'd0, irq_od}, 32'h0);
    pin_in = 2'b00; tick(1);
    pin_in = 2'b11; tick(1);
    pin_in = 2'b01; tick(1);
    pin_in = 2'b11;
    reset_n = 1'b1;
    tick(6);
    wr(2, 32'h3);
    rd_chk(3, "no warmup capture", 32'h0);
    check_all("rst2");

    // randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      pin_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), $urandom);
      else tick(1);
      check_all($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
